// File: rtl/loopback_module.sv
// Registered digital loopback: data_in reappears on data_out LATENCY cycles later,
// with a valid flag and a saturating transfer counter. Define LOOPBACK_PARITY_EN for parity outputs.
module loopback_module #(
    parameter int DATA_WIDTH = 8,
    parameter int LATENCY    = 1,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  out_valid,
    output logic [CNT_WIDTH-1:0]  xfer_count
`ifdef LOOPBACK_PARITY_EN
    ,
    output logic                  parity_out,
    output logic                  parity_err
`endif
);

    generate
        if (LATENCY < 1 || LATENCY > 16) begin : g_bad_latency
            $error("loopback_module: LATENCY must be in 1..16");
        end
        if (DATA_WIDTH < 1 || DATA_WIDTH > 64) begin : g_bad_width
            $error("loopback_module: DATA_WIDTH must be in 1..64");
        end
    endgenerate

    logic [DATA_WIDTH-1:0] stage [LATENCY];
    logic [LATENCY-1:0]    valid_chain;

    // Bit 0 of valid_chain is the newest stage, so the top bit qualifies data_out.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int k = 0; k < LATENCY; k++) begin
                stage[k] <= '0;
            end
            valid_chain <= '0;
        end else begin
            stage[0] <= data_in;
            for (int k = 1; k < LATENCY; k++) begin
                stage[k] <= stage[k-1];
            end
            valid_chain <= (valid_chain << 1) | LATENCY'(1);
        end
    end

    assign data_out  = stage[LATENCY-1];
    assign out_valid = valid_chain[LATENCY-1];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            xfer_count <= '0;
        end else if (out_valid && (xfer_count != '1)) begin
            xfer_count <= xfer_count + CNT_WIDTH'(1);
        end
    end

`ifdef LOOPBACK_PARITY_EN
    logic [LATENCY-1:0] parity_chain;
    logic               err_sticky;

    // Parity is taken at the input and travels beside the word, so a corrupted stage shows up as a mismatch.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            parity_chain <= '0;
            err_sticky   <= 1'b0;
        end else begin
            parity_chain <= (parity_chain << 1) | LATENCY'(^data_in);
            err_sticky   <= parity_err;
        end
    end

    assign parity_out = parity_chain[LATENCY-1];
    assign parity_err = err_sticky | (out_valid & ((^data_out) != parity_out));
`else
    // Without parity the pipeline carries only data and valid.
`endif

endmodule

// File: tb/tb_loopback_module.sv
// Self-checking bench for loopback_module: a LATENCY=1 and a LATENCY=3/CNT_WIDTH=4 instance
// share stimulus and are compared against a history-queue reference model.
module tb_loopback_module;

    logic        clk;
    logic        reset;
    logic [7:0]  data_in;

    logic [7:0]  u1_data_out;
    logic        u1_out_valid;
    logic [15:0] u1_xfer_count;
    logic [7:0]  u3_data_out;
    logic        u3_out_valid;
    logic [3:0]  u3_xfer_count;
`ifdef LOOPBACK_PARITY_EN
    logic        u1_parity_out, u1_parity_err;
    logic        u3_parity_out, u3_parity_err;
`endif

    int errors = 0;
    int checks = 0;
    logic [7:0] hist [$];

    loopback_module #(.DATA_WIDTH(8), .LATENCY(1), .CNT_WIDTH(16)) u1 (
        .clk        (clk),
        .reset      (reset),
        .data_in    (data_in),
        .data_out   (u1_data_out),
        .out_valid  (u1_out_valid),
        .xfer_count (u1_xfer_count)
`ifdef LOOPBACK_PARITY_EN
        ,
        .parity_out (u1_parity_out),
        .parity_err (u1_parity_err)
`endif
    );

    loopback_module #(.DATA_WIDTH(8), .LATENCY(3), .CNT_WIDTH(4)) u3 (
        .clk        (clk),
        .reset      (reset),
        .data_in    (data_in),
        .data_out   (u3_data_out),
        .out_valid  (u3_out_valid),
        .xfer_count (u3_xfer_count)
`ifdef LOOPBACK_PARITY_EN
        ,
        .parity_out (u3_parity_out),
        .parity_err (u3_parity_err)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model: after n edges since release, data_out holds the word sampled at edge n-LAT.
    function automatic logic [7:0] exp_data(input int lat);
        int n;
        n = hist.size();
        return (n >= lat) ? hist[n-lat] : 8'h00;
    endfunction

    function automatic logic exp_valid(input int lat);
        return hist.size() >= lat;
    endfunction

    function automatic longint exp_count(input int lat, input int cw);
        longint c;
        longint cmax;
        c    = longint'(hist.size()) - lat;
        cmax = (longint'(1) << cw) - 1;
        if (c < 0) c = 0;
        if (c > cmax) c = cmax;
        return c;
    endfunction

    task automatic check_output(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic check_all(input string ctx);
        check_output({ctx, " u1.data_out"},   64'(u1_data_out),   64'(exp_data(1)));
        check_output({ctx, " u1.out_valid"},  64'(u1_out_valid),  64'(exp_valid(1)));
        check_output({ctx, " u1.xfer_count"}, 64'(u1_xfer_count), 64'(exp_count(1, 16)));
        check_output({ctx, " u3.data_out"},   64'(u3_data_out),   64'(exp_data(3)));
        check_output({ctx, " u3.out_valid"},  64'(u3_out_valid),  64'(exp_valid(3)));
        check_output({ctx, " u3.xfer_count"}, 64'(u3_xfer_count), 64'(exp_count(3, 4)));
`ifdef LOOPBACK_PARITY_EN
        check_output({ctx, " u1.parity_out"}, 64'(u1_parity_out), 64'(^exp_data(1)));
        check_output({ctx, " u1.parity_err"}, 64'(u1_parity_err), 64'(0));
        check_output({ctx, " u3.parity_out"}, 64'(u3_parity_out), 64'(^exp_data(3)));
        check_output({ctx, " u3.parity_err"}, 64'(u3_parity_err), 64'(0));
`endif
    endtask

    // Drive one word, let one edge sample it, then check just after the edge.
    task automatic apply_stimulus(input logic [7:0] word, input string ctx);
        data_in = word;
        @(posedge clk);
        if (reset) hist.push_back(word);
        #1;
        check_all($sformatf("%s edge%0d in=%02h", ctx, hist.size(), word));
    endtask

    initial begin
        logic [7:0] dir_words [7];
        dir_words = '{8'h55, 8'hAA, 8'hFF, 8'h01, 8'h02, 8'h03, 8'h04};

        reset   = 1'b0;
        data_in = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        check_all("reset hold");

        reset = 1'b1;
        #2;
        $display("[TB] directed loop and latency words");
        for (int i = 0; i < 7; i++) begin
            apply_stimulus(dir_words[i], "directed");
        end
        apply_stimulus(8'h07, "parity07");
        apply_stimulus(8'hFF, "parityFF");
        apply_stimulus(8'h00, "zero");
        apply_stimulus(8'h00, "zero");

        $display("[TB] random words, counter saturation");
        for (int i = 0; i < 20; i++) begin
            apply_stimulus(8'($urandom), "random");
        end

        $display("[TB] reset mid-stream");
        apply_stimulus(8'hAA, "inflight");
        reset = 1'b0;
        hist.delete();
        #1;
        check_all("async reset");
        apply_stimulus(8'h5A, "held in reset");
        #2;
        reset = 1'b1;
        for (int i = 0; i < 6; i++) begin
            apply_stimulus(8'($urandom), "after reset");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
